// File: rtl/tb_phase_sequencer.sv
`timescale 1ns/1ps
// Test-phase sequencer on the bench virtual clock: DUT reset, settle, stimulate, then N measurement handshakes.
// Defining TB_SEQ_TIMEOUT_EN enables the SETTLE/MEASURE watchdog; otherwise timeout is tied low.
module tb_phase_sequencer #(
    parameter int RST_CYC     = 4,
    parameter int SETTLE_CYC  = 16,
    parameter int RUN_CYC     = 64,
    parameter int N_MEAS      = 8,
    parameter int CW          = 16,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic          clk,
    input  logic          rstb,
    input  logic          start,
    input  logic          abort,
    input  logic          dut_ready,
    input  logic          meas_ack,
    output logic          dut_rstb,
    output logic          stim_en,
    output logic          meas_req,
    output logic [7:0]    meas_idx,
    output logic [2:0]    phase,
    output logic [CW-1:0] cyc_cnt,
    output logic          done,
    output logic          timeout
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        DUT_RST = 3'd1,
        SETTLE  = 3'd2,
        RUN     = 3'd3,
        MEASURE = 3'd4,
        DONE    = 3'd5
    } phase_e;

    localparam logic [CW-1:0] RST_LAST    = CW'(RST_CYC - 1);
    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYC - 1);
    localparam logic [CW-1:0] RUN_LAST    = CW'(RUN_CYC - 1);
    localparam logic [7:0]    IDX_LAST    = 8'(N_MEAS - 1);

    phase_e        phase_q, phase_d;
    logic [CW-1:0] cyc_cnt_q, cyc_cnt_d;
    logic          dut_rstb_q, dut_rstb_d;
    logic          stim_en_q, stim_en_d;
    logic          meas_req_q, meas_req_d;
    logic [7:0]    meas_idx_q, meas_idx_d;
    logic          done_q, done_d;
    logic          timeout_q, timeout_d;
    logic          wdog_hit;

`ifdef TB_SEQ_TIMEOUT_EN
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYC - 1);
    assign wdog_hit = (cyc_cnt_q == TMO_LAST);
`else
    localparam int timeout_cyc_unused = TIMEOUT_CYC;
    assign wdog_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            phase_q    <= IDLE;
            cyc_cnt_q  <= '0;
            dut_rstb_q <= 1'b0;
            stim_en_q  <= 1'b0;
            meas_req_q <= 1'b0;
            meas_idx_q <= 8'd0;
            done_q     <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            phase_q    <= phase_d;
            cyc_cnt_q  <= cyc_cnt_d;
            dut_rstb_q <= dut_rstb_d;
            stim_en_q  <= stim_en_d;
            meas_req_q <= meas_req_d;
            meas_idx_q <= meas_idx_d;
            done_q     <= done_d;
            timeout_q  <= timeout_d;
        end
    end

    always_comb begin
        phase_d    = phase_q;
        dut_rstb_d = dut_rstb_q;
        stim_en_d  = stim_en_q;
        meas_req_d = meas_req_q;
        meas_idx_d = meas_idx_q;
        done_d     = done_q;
        timeout_d  = timeout_q;

        if (abort) begin
            phase_d    = IDLE;
            dut_rstb_d = 1'b0;
            stim_en_d  = 1'b0;
            meas_req_d = 1'b0;
            meas_idx_d = 8'd0;
            done_d     = 1'b0;
            timeout_d  = 1'b0;
        end else begin
            case (phase_q)
                IDLE: begin
                    dut_rstb_d = 1'b0;
                    stim_en_d  = 1'b0;
                    meas_req_d = 1'b0;
                    if (start) begin
                        phase_d    = DUT_RST;
                        meas_idx_d = 8'd0;
                        done_d     = 1'b0;
                        timeout_d  = 1'b0;
                    end
                end
                DUT_RST: begin
                    if (cyc_cnt_q == RST_LAST) begin
                        phase_d    = SETTLE;
                        dut_rstb_d = 1'b1;
                    end
                end
                SETTLE: begin
                    if (cyc_cnt_q >= SETTLE_LAST && dut_ready) begin
                        phase_d   = RUN;
                        stim_en_d = 1'b1;
                    end else if (wdog_hit) begin
                        phase_d   = DONE;
                        done_d    = 1'b1;
                        timeout_d = 1'b1;
                    end
                end
                RUN: begin
                    if (cyc_cnt_q == RUN_LAST) begin
                        phase_d    = MEASURE;
                        stim_en_d  = 1'b0;
                        meas_req_d = 1'b1;
                        meas_idx_d = 8'd0;
                    end
                end
                MEASURE: begin
                    // Only the final handshake counts as the exit condition for the watchdog.
                    if (meas_req_q && meas_ack && meas_idx_q == IDX_LAST) begin
                        phase_d    = DONE;
                        meas_req_d = 1'b0;
                        done_d     = 1'b1;
                    end else if (wdog_hit) begin
                        phase_d    = DONE;
                        meas_req_d = 1'b0;
                        done_d     = 1'b1;
                        timeout_d  = 1'b1;
                    end else if (meas_req_q && meas_ack) begin
                        meas_req_d = 1'b0;
                        meas_idx_d = meas_idx_q + 8'd1;
                    end else if (!meas_req_q) begin
                        meas_req_d = 1'b1;
                    end
                end
                DONE: begin
                    if (start) begin
                        phase_d    = DUT_RST;
                        dut_rstb_d = 1'b0;
                        meas_idx_d = 8'd0;
                        done_d     = 1'b0;
                        timeout_d  = 1'b0;
                    end
                end
                default: begin
                    phase_d    = IDLE;
                    dut_rstb_d = 1'b0;
                    stim_en_d  = 1'b0;
                    meas_req_d = 1'b0;
                    meas_idx_d = 8'd0;
                    done_d     = 1'b0;
                    timeout_d  = 1'b0;
                end
            endcase
        end
    end

    // IDLE is a parked state rather than a timed phase, so the counter stays at zero there.
    always_comb begin
        cyc_cnt_d = cyc_cnt_q;
        if (abort || phase_d != phase_q || phase_q == IDLE) begin
            cyc_cnt_d = '0;
        end else if (cyc_cnt_q != '1) begin
            cyc_cnt_d = cyc_cnt_q + CW'(1);
        end
    end

    assign phase    = phase_q;
    assign cyc_cnt  = cyc_cnt_q;
    assign dut_rstb = dut_rstb_q;
    assign stim_en  = stim_en_q;
    assign meas_req = meas_req_q;
    assign meas_idx = meas_idx_q;
    assign done     = done_q;
    assign timeout  = timeout_q;

endmodule

// File: tb/tb_tb_phase_sequencer.sv
`timescale 1ns/1ps
// Self-checking bench for tb_phase_sequencer: per-cycle expected snapshots are queued
// from a timeline model when a sequence is launched and popped as the DUT advances.
module tb_tb_phase_sequencer;

    localparam int RST_CYC    = 4;
    localparam int SETTLE_CYC = 16;
    localparam int RUN_CYC    = 64;
    localparam int N_MEAS     = 8;
    localparam int CW         = 16;
`ifdef TB_SEQ_TIMEOUT_EN
    localparam int TIMEOUT_CYC = 32;
    localparam int LATE_READY  = 24;
`else
    localparam int TIMEOUT_CYC = 1024;
    localparam int LATE_READY  = 40;
`endif
    localparam int S_MEAS_NOMINAL = RST_CYC + SETTLE_CYC + RUN_CYC;

    logic          clk = 1'b0;
    logic          rstb;
    logic          start;
    logic          abort;
    logic          dut_ready;
    logic          meas_ack;
    logic          dut_rstb;
    logic          stim_en;
    logic          meas_req;
    logic [7:0]    meas_idx;
    logic [2:0]    phase;
    logic [CW-1:0] cyc_cnt;
    logic          done;
    logic          timeout;

    typedef struct packed {
        logic [2:0]  ph;
        logic [15:0] cyc;
        logic        rstb;
        logic        stim;
        logic        req;
        logic [7:0]  idx;
        logic        done;
        logic        tmo;
    } snap_t;

    snap_t exp_q[$];
    int    checks = 0;
    int    errors = 0;

    tb_phase_sequencer #(
        .RST_CYC    (RST_CYC),
        .SETTLE_CYC (SETTLE_CYC),
        .RUN_CYC    (RUN_CYC),
        .N_MEAS     (N_MEAS),
        .CW         (CW),
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk      (clk),
        .rstb     (rstb),
        .start    (start),
        .abort    (abort),
        .dut_ready(dut_ready),
        .meas_ack (meas_ack),
        .dut_rstb (dut_rstb),
        .stim_en  (stim_en),
        .meas_req (meas_req),
        .meas_idx (meas_idx),
        .phase    (phase),
        .cyc_cnt  (cyc_cnt),
        .done     (done),
        .timeout  (timeout)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL global_time_limit got running want finished");
        $fatal(1, "[TB] time limit");
    end

    function automatic snap_t observe();
        snap_t s;
        s.ph   = phase;
        s.cyc  = cyc_cnt;
        s.rstb = dut_rstb;
        s.stim = stim_en;
        s.req  = meas_req;
        s.idx  = meas_idx;
        s.done = done;
        s.tmo  = timeout;
        return s;
    endfunction

    function automatic string fmt(snap_t s);
        return $sformatf("ph=%0d cyc=%0d rstb=%0b stim=%0b req=%0b idx=%0d done=%0b to=%0b",
                         s.ph, s.cyc, s.rstb, s.stim, s.req, s.idx, s.done, s.tmo);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Launch one sequence and compare every cycle against the timeline model.
    task automatic run_profile(input string name, input int ready_at,
                               input bit ack_always, input bit hold_start);
        int    s_settle, settle_len, s_run, s_meas, done_t, t_end;
        snap_t e, o;
        s_settle   = RST_CYC;
        settle_len = (ready_at < 0) ? SETTLE_CYC
                   : ((ready_at + 1 > SETTLE_CYC) ? ready_at + 1 : SETTLE_CYC);
        s_run      = s_settle + settle_len;
        s_meas     = s_run + RUN_CYC;
        done_t     = s_meas + 2 * N_MEAS - 1;
        t_end      = done_t + 3;
        for (int t = 0; t <= t_end; t++) begin
            e = '0;
            if (t < s_settle) begin
                e.ph  = 3'd1;
                e.cyc = 16'(t);
            end else if (t < s_run) begin
                e.ph  = 3'd2;
                e.cyc = 16'(t - s_settle);
            end else if (t < s_meas) begin
                e.ph   = 3'd3;
                e.cyc  = 16'(t - s_run);
                e.stim = 1'b1;
            end else if (t < done_t) begin
                e.ph  = 3'd4;
                e.cyc = 16'(t - s_meas);
                e.req = ((t - s_meas) % 2 == 0);
                e.idx = 8'((t - s_meas + 1) / 2);
            end else begin
                e.ph   = 3'd5;
                e.cyc  = 16'(t - done_t);
                e.idx  = 8'(N_MEAS - 1);
                e.done = 1'b1;
            end
            e.rstb = (t >= s_settle);
            exp_q.push_back(e);
        end
        start     = 1'b1;
        abort     = 1'b0;
        meas_ack  = 1'b0;
        dut_ready = (ready_at < 0);
        for (int t = 0; t <= t_end; t++) begin
            tick();
            o = observe();
            e = exp_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("[TB] FAIL %s t=%0d got %s want %s", name, t, fmt(o), fmt(e));
            end
            start     = hold_start && (t + 1 < done_t);
            dut_ready = (ready_at < 0) || (t >= s_settle + ready_at);
            meas_ack  = ack_always ? 1'b1 : meas_req;
        end
        start    = 1'b0;
        meas_ack = 1'b0;
    endtask

    task automatic test_reset();
        snap_t o;
        rstb      = 1'b0;
        start     = 1'b0;
        abort     = 1'b0;
        dut_ready = 1'b0;
        meas_ack  = 1'b0;
        #2;
        o = observe();
        checks++;
        if (o !== snap_t'(0)) begin
            errors++;
            $display("[TB] FAIL reset_asserted got %s want all zero", fmt(o));
        end
        repeat (3) tick();
        #2 rstb = 1'b1;
        repeat (20) tick();
        o = observe();
        checks++;
        if (o !== snap_t'(0)) begin
            errors++;
            $display("[TB] FAIL reset_idle_20 got %s want all zero", fmt(o));
        end
    endtask

    task automatic test_full_run();
        run_profile("full_run", -1, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        run_profile("restart_hold_start", -1, 1'b0, 1'b1);
    endtask

    task automatic test_late_ready();
        run_profile("late_ready_ack_high", LATE_READY, 1'b1, 1'b0);
    endtask

    task automatic test_abort();
        bit    found;
        snap_t o, e;
        found     = 1'b0;
        start     = 1'b1;
        dut_ready = 1'b1;
        meas_ack  = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin
            tick();
            start = 1'b0;
            if (meas_req === 1'b1 && meas_idx === 8'd3) found = 1'b1;
            else meas_ack = meas_req;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("[TB] FAIL abort_reach_idx3 got idx=%0d req=%0b want idx=3 req=1", meas_idx, meas_req);
        end
        exp_q.push_back('0);
        exp_q.push_back('0);
        abort    = 1'b1;
        meas_ack = 1'b1;
        start    = 1'b1;
        tick();
        o = observe();
        e = exp_q.pop_front();
        checks++;
        if (o !== e) begin
            errors++;
            $display("[TB] FAIL abort_with_ack got %s want %s", fmt(o), fmt(e));
        end
        abort    = 1'b0;
        meas_ack = 1'b0;
        start    = 1'b0;
        tick();
        o = observe();
        e = exp_q.pop_front();
        checks++;
        if (o !== e) begin
            errors++;
            $display("[TB] FAIL abort_stays_idle got %s want %s", fmt(o), fmt(e));
        end
    endtask

    task automatic test_watchdog();
        start     = 1'b1;
        dut_ready = 1'b1;
        meas_ack  = 1'b0;
        for (int t = 0; t <= S_MEAS_NOMINAL; t++) begin
            tick();
            start = 1'b0;
        end
        checks++;
        if (phase !== 3'd4 || meas_req !== 1'b1 || meas_idx !== 8'd0 || cyc_cnt !== 16'd0) begin
            errors++;
            $display("[TB] FAIL wdog_enter_measure got ph=%0d req=%0b idx=%0d cyc=%0d want ph=4 req=1 idx=0 cyc=0",
                     phase, meas_req, meas_idx, cyc_cnt);
        end
`ifdef TB_SEQ_TIMEOUT_EN
        repeat (TIMEOUT_CYC - 2) tick();
        checks++;
        if (phase !== 3'd4 || timeout !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL wdog_before_fire got ph=%0d to=%0b done=%0b want ph=4 to=0 done=0",
                     phase, timeout, done);
        end
        tick();
        checks++;
        if (phase !== 3'd5 || timeout !== 1'b1 || done !== 1'b1 || meas_req !== 1'b0 || dut_rstb !== 1'b1) begin
            errors++;
            $display("[TB] FAIL wdog_fire got ph=%0d to=%0b done=%0b req=%0b rstb=%0b want ph=5 to=1 done=1 req=0 rstb=1",
                     phase, timeout, done, meas_req, dut_rstb);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (phase !== 3'd1 || timeout !== 1'b0 || done !== 1'b0 || dut_rstb !== 1'b0 || meas_idx !== 8'd0) begin
            errors++;
            $display("[TB] FAIL wdog_restart got ph=%0d to=%0b done=%0b rstb=%0b idx=%0d want ph=1 to=0 done=0 rstb=0 idx=0",
                     phase, timeout, done, dut_rstb, meas_idx);
        end
`else
        repeat (2000) tick();
        checks++;
        if (phase !== 3'd4 || timeout !== 1'b0 || meas_req !== 1'b1 || meas_idx !== 8'd0 || cyc_cnt !== 16'd2000) begin
            errors++;
            $display("[TB] FAIL no_wdog_2000 got ph=%0d to=%0b req=%0b idx=%0d cyc=%0d want ph=4 to=0 req=1 idx=0 cyc=2000",
                     phase, timeout, meas_req, meas_idx, cyc_cnt);
        end
`endif
        abort = 1'b1;
        tick();
        abort = 1'b0;
    endtask

    task automatic test_async_reset();
        snap_t o;
        start     = 1'b1;
        dut_ready = 1'b1;
        meas_ack  = 1'b0;
        for (int t = 0; t < 30; t++) begin
            tick();
            start = 1'b0;
        end
        checks++;
        if (phase !== 3'd3 || stim_en !== 1'b1 || dut_rstb !== 1'b1) begin
            errors++;
            $display("[TB] FAIL async_setup got ph=%0d stim=%0b rstb=%0b want ph=3 stim=1 rstb=1",
                     phase, stim_en, dut_rstb);
        end
        #3 rstb = 1'b0;
        #1;
        o = observe();
        checks++;
        if (o !== snap_t'(0)) begin
            errors++;
            $display("[TB] FAIL async_reset_immediate got %s want all zero", fmt(o));
        end
        tick();
        #2 rstb = 1'b1;
        repeat (2) tick();
        o = observe();
        checks++;
        if (o !== snap_t'(0)) begin
            errors++;
            $display("[TB] FAIL async_reset_release got %s want all zero", fmt(o));
        end
    endtask

    initial begin
        test_reset();
        test_full_run();
        test_back_to_back();
        test_late_ready();
        test_abort();
        test_watchdog();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
